// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - decode/issue handshake bundle between front end, issue stage and ALU
interface alu_issue_stage_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              instr;
    logic [DATA_WIDTH-1:0]    pc;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic                     illegal;

    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, out_valid, SrcA, SrcB, Operation, illegal
    );

    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
        output in_ready, out_valid, SrcA, SrcB, Operation, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I decode into ALU Operation/SrcA/SrcB behind a one-entry valid/ready register
module alu_issue_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    alu_issue_stage_if.slave  bus
);
    typedef enum logic [3:0] {
        OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0011,
        OP_XOR = 4'b0100, OP_SLL = 4'b0101, OP_SRL = 4'b0110, OP_SRA = 4'b0111,
        OP_EQ  = 4'b1000, OP_NE  = 4'b1001, OP_LT  = 4'b1010, OP_GE  = 4'b1011,
        OP_JAL = 4'b1100, OP_ILLEGAL = 4'b1111
    } alu_op_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_j, imm_u, shamt_r, shamt_i;

    alu_op_e               dec_op;
    logic [DATA_WIDTH-1:0] dec_a, dec_b;
    logic                  dec_ill;

    logic                  out_valid_d, out_valid_q;
    logic                  illegal_d, illegal_q;
    alu_op_e               op_d, op_q;
    logic [DATA_WIDTH-1:0] src_a_d, src_a_q, src_b_d, src_b_q;
    logic                  capture;

    assign opcode  = bus.instr[6:0];
    assign funct3  = bus.instr[14:12];
    assign funct7  = bus.instr[31:25];
    assign imm_i   = DATA_WIDTH'(signed'(bus.instr[31:20]));
    assign imm_s   = DATA_WIDTH'(signed'({bus.instr[31:25], bus.instr[11:7]}));
    assign imm_j   = DATA_WIDTH'(signed'({bus.instr[31], bus.instr[19:12], bus.instr[20],
                                          bus.instr[30:21], 1'b0}));
    assign imm_u   = DATA_WIDTH'(signed'({bus.instr[31:12], 12'b0}));
    assign shamt_r = DATA_WIDTH'(bus.rs2_data[4:0]);
    assign shamt_i = DATA_WIDTH'(bus.instr[24:20]);

    always_comb begin
        dec_op  = OP_ADD;
        dec_a   = bus.rs1_data;
        dec_b   = bus.rs2_data;
        dec_ill = 1'b0;
        case (opcode)
            OPC_R: begin
                case ({funct7, funct3})
                    10'b0000000_000: dec_op = OP_ADD;
                    10'b0100000_000: dec_op = OP_SUB;
                    10'b0000000_111: dec_op = OP_AND;
                    10'b0000000_110: dec_op = OP_OR;
                    10'b0000000_100: dec_op = OP_XOR;
                    10'b0000000_010: dec_op = OP_LT;
                    10'b0000000_001: begin dec_op = OP_SLL; dec_b = shamt_r; end
                    10'b0000000_101: begin dec_op = OP_SRL; dec_b = shamt_r; end
                    10'b0100000_101: begin dec_op = OP_SRA; dec_b = shamt_r; end
                    default:         dec_ill = 1'b1;
                endcase
            end
            OPC_I: begin
                dec_b = imm_i;
                case (funct3)
                    3'b000: dec_op = OP_ADD;
                    3'b111: dec_op = OP_AND;
                    3'b110: dec_op = OP_OR;
                    3'b100: dec_op = OP_XOR;
                    3'b010: dec_op = OP_LT;
                    3'b001: begin dec_op = OP_SLL; dec_b = shamt_i; dec_ill = (funct7 != 7'b0000000); end
                    3'b101: begin
                        dec_b = shamt_i;
                        if (funct7 == 7'b0000000)      dec_op = OP_SRL;
                        else if (funct7 == 7'b0100000) dec_op = OP_SRA;
                        else                           dec_ill = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  dec_op = OP_EQ;
                    3'b001:  dec_op = OP_NE;
                    3'b100:  dec_op = OP_LT;
                    3'b101:  dec_op = OP_GE;
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_LOAD:  dec_b = imm_i;
            OPC_STORE: dec_b = imm_s;
            OPC_JAL:   begin dec_op = OP_JAL; dec_a = bus.pc; dec_b = imm_j; end
            OPC_LUI:   begin dec_a = '0; dec_b = imm_u; end
            OPC_AUIPC: begin dec_a = bus.pc; dec_b = imm_u; end
            default:   dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_op = OP_ILLEGAL;
            dec_a  = '0;
            dec_b  = '0;
        end
    end

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

    // Flush clears valid and illegal only; operand fields keep their last value.
    always_comb begin
        out_valid_d = out_valid_q;
        illegal_d   = illegal_q;
        op_d        = op_q;
        src_a_d     = src_a_q;
        src_b_d     = src_b_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
            illegal_d   = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
            illegal_d   = dec_ill;
            op_d        = dec_op;
            src_a_d     = dec_a;
            src_b_d     = dec_b;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            op_q        <= OP_AND;
            src_a_q     <= '0;
            src_b_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            op_q        <= op_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.illegal   = illegal_q;
    assign bus.Operation = OPCODE_LENGTH'(op_q);
    assign bus.SrcA      = src_a_q;
    assign bus.SrcB      = src_b_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - randomized and directed bench for alu_issue_stage against a queue-based model
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } ent_t;

    ent_t q[$];
    ent_t cur;
    bit   m_init = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                        input logic [31:0] r1, input logic [31:0] r2);
        ent_t        e;
        logic [31:0] ii, is, iu, ij, t;
        logic [6:0]  f7;
        logic [2:0]  f3;
        bit          ok;
        f7 = ins[31:25];
        f3 = ins[14:12];
        ii = $signed(ins) >>> 20;
        is = (ii & ~32'h1F) | ((ins >> 7) & 32'h1F);
        iu = ins & 32'hFFFFF000;
        t  = $signed(ins) >>> 11;
        ij = (t & 32'hFFF00000) | (ins & 32'h000FF000) | ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
        ok = 1'b1;
        e.ill = 1'b0;
        e.a = r1;
        e.b = r2;
        e.op = 4'h2;
        case (ins[6:0])
            7'h33: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: e.op = 4'h2;
                        3'd7: e.op = 4'h0;
                        3'd6: e.op = 4'h1;
                        3'd4: e.op = 4'h4;
                        3'd2: e.op = 4'hA;
                        3'd1: begin e.op = 4'h5; e.b = r2 % 32; end
                        3'd5: begin e.op = 4'h6; e.b = r2 % 32; end
                        default: ok = 1'b0;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) e.op = 4'h3;
                else if (f7 == 7'h20 && f3 == 3'd5) begin e.op = 4'h7; e.b = r2 % 32; end
                else ok = 1'b0;
            end
            7'h13: begin
                e.b = ii;
                case (f3)
                    3'd0: e.op = 4'h2;
                    3'd7: e.op = 4'h0;
                    3'd6: e.op = 4'h1;
                    3'd4: e.op = 4'h4;
                    3'd2: e.op = 4'hA;
                    3'd1: begin e.op = 4'h5; e.b = (ins >> 20) % 32; ok = (f7 == 0); end
                    3'd5: begin
                        e.b = (ins >> 20) % 32;
                        e.op = (f7 == 7'h20) ? 4'h7 : 4'h6;
                        ok = (f7 == 0) || (f7 == 7'h20);
                    end
                    default: ok = 1'b0;
                endcase
            end
            7'h63: begin
                if (f3 == 0) e.op = 4'h8;
                else if (f3 == 1) e.op = 4'h9;
                else if (f3 == 4) e.op = 4'hA;
                else if (f3 == 5) e.op = 4'hB;
                else ok = 1'b0;
            end
            7'h03: e.b = ii;
            7'h23: e.b = is;
            7'h6F: begin e.op = 4'hC; e.a = pcv; e.b = ij; end
            7'h37: begin e.a = 0; e.b = iu; end
            7'h17: begin e.a = pcv; e.b = iu; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.op = 4'hF; e.a = 0; e.b = 0; e.ill = 1'b1;
        end
        return e;
    endfunction

    // Called at a negedge; leaves the bench at the following negedge with outputs checked.
    task automatic drive(input logic rst, input logic v, input logic fl, input logic ordy,
                         input logic [31:0] ins, input logic [31:0] pcv,
                         input logic [31:0] r1, input logic [31:0] r2);
        bit acc;
        rst_n         = rst;
        bus.in_valid  = v;
        bus.flush     = fl;
        bus.out_ready = ordy;
        bus.instr     = ins;
        bus.pc        = pcv;
        bus.rs1_data  = r1;
        bus.rs2_data  = r2;
        #1;
        if (m_init) chk("in_ready", {31'b0, bus.in_ready}, {31'b0, (q.size() == 0) || ordy});
        @(posedge clk);
        if (!rst) begin
            q.delete();
            cur = '0;
            m_init = 1'b1;
        end else if (fl) begin
            q.delete();
            cur.ill = 1'b0;
        end else begin
            acc = v && (q.size() == 0 || ordy);
            if (ordy && q.size() != 0) void'(q.pop_front());
            if (acc) begin
                cur = ref_decode(ins, pcv, r1, r2);
                q.push_back(cur);
            end
        end
        @(negedge clk);
        if (m_init) begin
            chk("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() != 0});
            chk("illegal", {31'b0, bus.illegal}, {31'b0, cur.ill});
            chk("op", {28'b0, bus.Operation}, {28'b0, cur.op});
            chk("src_a", bus.SrcA, cur.a);
            chk("src_b", bus.SrcB, cur.b);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  opcs [9];
        int          k, f;
        opcs = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h6F, 7'h37, 7'h17, 7'h67};
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 9) w[6:0] = opcs[k];
        f = $urandom_range(0, 3);
        if (f == 0) w[31:25] = 7'h00;
        else if (f == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    logic [3:0]  sv_op;
    logic [31:0] sv_a, sv_b;

    initial begin
        bus.in_valid = 0; bus.flush = 0; bus.out_ready = 0;
        bus.instr = 0; bus.pc = 0; bus.rs1_data = 0; bus.rs2_data = 0; rst_n = 0;
        @(negedge clk);
        drive(0, 1, 0, 1, 32'hFFB10093, 32'h100, 32'd10, 32'd3);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_op", {28'b0, bus.Operation}, 32'd0);

        drive(1, 1, 0, 1, 32'hFFB10093, 32'h100, 32'd10, 32'd3);
        chk("addi_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("addi_op", {28'b0, bus.Operation}, 32'h2);
        chk("addi_a", bus.SrcA, 32'd10);
        chk("addi_b", bus.SrcB, 32'hFFFFFFFB);

        drive(1, 1, 0, 1, 32'h40315133, 32'h104, 32'h80000000, 32'h24);
        chk("sra_op", {28'b0, bus.Operation}, 32'h7);
        chk("sra_b", bus.SrcB, 32'h4);

        drive(1, 1, 0, 1, 32'h00208463, 32'h200, 32'd7, 32'd7);
        chk("beq_op", {28'b0, bus.Operation}, 32'h8);
        drive(1, 1, 0, 1, 32'h008000EF, 32'h204, 32'd1, 32'd2);
        chk("jal_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("jal_op", {28'b0, bus.Operation}, 32'hC);
        chk("jal_a", bus.SrcA, 32'h204);
        chk("jal_b", bus.SrcB, 32'h8);

        sv_op = bus.Operation; sv_a = bus.SrcA; sv_b = bus.SrcB;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 32'h00A00093 + i, 32'h300, 32'd5, 32'd6);
            chk("hold_op", {28'b0, bus.Operation}, {28'b0, sv_op});
            chk("hold_a", bus.SrcA, sv_a);
            chk("hold_b", bus.SrcB, sv_b);
        end
        drive(1, 1, 0, 1, 32'h00A00093, 32'h300, 32'd5, 32'd6);
        chk("release_b", bus.SrcB, 32'd10);

        drive(1, 1, 0, 1, 32'h0020B0B3, 32'h400, 32'd1, 32'd2);
        chk("sltu_op", {28'b0, bus.Operation}, 32'hF);
        chk("sltu_ill", {31'b0, bus.illegal}, 32'd1);
        chk("sltu_valid", {31'b0, bus.out_valid}, 32'd1);
        drive(1, 1, 1, 0, 32'hFFB10093, 32'h404, 32'd10, 32'd0);
        chk("flush_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("flush_ill", {31'b0, bus.illegal}, 32'd0);

        drive(1, 1, 0, 0, 32'h00500113, 32'h500, 32'd9, 32'd9);
        drive(0, 1, 0, 0, 32'h00500113, 32'h504, 32'd9, 32'd9);
        chk("rst_mid_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_mid_a", bus.SrcA, 32'd0);
        chk("rst_mid_ready", {31'b0, bus.in_ready}, 32'd1);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
                  rand_instr(), $urandom, $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
